// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a held WIDTH-bit pattern out MSB-first `reps` times, then pulses done (SERIAL_TX_PARITY_EN appends an even-parity bit per repetition).
// Latency: first bit on w one edge after start is accepted; repetitions are back-to-back with no gap cycle.
// Backpressure: none; start is only sampled in IDLE, and pattern/reps changes while busy are ignored.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sreg;
    logic [BC_W-1:0]  bitcnt;
    logic [CNT_W-1:0] repcnt;
    logic             more_reps;

    // repcnt holds the repetitions still owed including the current one
    assign more_reps = (repcnt > CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            hold    <= '0;
            sreg    <= '0;
            bitcnt  <= '0;
            repcnt  <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        hold   <= pattern;
                        sreg   <= pattern;
                        repcnt <= reps;
                        bitcnt <= LAST_BIT;
                        busy   <= 1'b1;
                        if (reps != '0) begin
                            state   <= SHIFT;
                            w       <= pattern[WIDTH-1];
                            w_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (bitcnt != '0) begin
                        sreg   <= sreg << 1;
                        w      <= sreg[WIDTH-2];
                        bitcnt <= bitcnt - BC_W'(1);
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state <= PARITY;
                        w     <= ^hold;
`else
                        if (more_reps) begin
                            repcnt <= repcnt - CNT_W'(1);
                            sreg   <= hold;
                            bitcnt <= LAST_BIT;
                            w      <= hold[WIDTH-1];
                        end else begin
                            state   <= DONE;
                            w       <= 1'b0;
                            w_valid <= 1'b0;
                            done    <= 1'b1;
                        end
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (more_reps) begin
                        state  <= SHIFT;
                        repcnt <= repcnt - CNT_W'(1);
                        sreg   <= hold;
                        bitcnt <= LAST_BIT;
                        w      <= hold[WIDTH-1];
                    end else begin
                        state   <= DONE;
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a frame-level model queues the expected {w,w_valid,busy,done} per cycle.
module tb_serial_pattern_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] reps = '0;
    logic       w, w_valid, busy, done;

    serial_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .pattern(pattern), .reps(reps),
        .w(w), .w_valid(w_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] q[$];
    logic [3:0] exp_v;
    logic [31:0] rx;
    int nvalid, nbusy, ndone, zcnt;
    logic prevw;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Expected output sequence for one accepted start, built directly from the frame rules.
    task automatic model_push(input logic [7:0] p, input logic [3:0] r);
        for (int k = 0; k < int'(r); k++) begin
            for (int i = 7; i >= 0; i--) q.push_back({p[i], 1'b1, 1'b1, 1'b0});
            if (PAR == 1) q.push_back({^p, 1'b1, 1'b1, 1'b0});
        end
        q.push_back(4'b0011);
    endtask

    task automatic clear_stats();
        rx = '0; nvalid = 0; nbusy = 0; ndone = 0; zcnt = 0; prevw = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 4'b0000;
        check("outs{w,wv,busy,done}", {28'd0, w, w_valid, busy, done}, {28'd0, exp_v});
        if (w_valid) begin
            rx = {rx[30:0], w};
            nvalid++;
            if (w && prevw) zcnt++;
        end
        prevw = w_valid & w;
        if (busy) nbusy++;
        if (done) ndone++;
    end

    task automatic send(input logic [7:0] p, input logic [3:0] r);
        @(posedge clk);
        #1;
        start = 1'b1; pattern = p; reps = r;
        @(posedge clk);
        model_push(p, r);
        #1;
        start = 1'b0; pattern = ~p; reps = r + 4'd1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_stats();
        #13;
        check("reset_state", {28'd0, w, w_valid, busy, done}, 32'd0);
        #10 resetn = 1'b1;

        // single pattern, reps=1
        clear_stats();
        send(8'b1011_0110, 4'd1);
        drain();
        check("single_bits", rx, (PAR == 1) ? 32'h16D : 32'hB6);
        check("single_nvalid", nvalid, 8 + PAR);
        check("single_nbusy", nbusy, 9 + PAR);
        check("single_ndone", ndone, 1);

        // repeats of all-ones, with a two-ones detector on w
        clear_stats();
        send(8'hFF, 4'd3);
        drain();
        check("rep_nvalid", nvalid, 24 + 3 * PAR);
        check("rep_z_count", zcnt, (PAR == 1) ? 21 : 23);
        check("rep_ndone", ndone, 1);

        // zero repeats
        clear_stats();
        send(8'hA5, 4'd0);
        drain();
        check("zero_nvalid", nvalid, 0);
        check("zero_nbusy", nbusy, 1);
        check("zero_ndone", ndone, 1);

        // start pulsed while busy must be ignored
        clear_stats();
        send(8'hF0, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; pattern = 8'h00; reps = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        check("busy_start_bits", rx, (PAR == 1) ? 32'h1E0 : 32'hF0);
        check("busy_start_ndone", ndone, 1);

        // max repeat count
        clear_stats();
        send(8'h3C, 4'd15);
        drain();
        check("max_nvalid", nvalid, 15 * (8 + PAR));
        check("max_ndone", ndone, 1);

        // asynchronous reset during the 5th bit
        clear_stats();
        send(8'hF0, 4'd1);
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_wv", {31'd0, w_valid}, 32'd1);
        resetn = 1'b0;
        q.delete();
        #1;
        check("async_reset_outs", {28'd0, w, w_valid, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        clear_stats();
        send(8'h81, 4'd1);
        drain();
        check("post_reset_bits", rx, (PAR == 1) ? 32'h102 : 32'h81);
        check("post_reset_ndone", ndone, 1);

        if (PAR == 1) begin
            clear_stats();
            send(8'b1011_0110, 4'd2);
            drain();
            check("parity_bits", rx, 32'h2DB6D);
            check("parity_nbusy", nbusy, 19);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
